// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and elaboration-time helpers for the modulo up/down counter.
package counter_updown_mod_pkg;

  localparam bit MODE_LEVEL = 1'b0;
  localparam bit MODE_EDGE  = 1'b1;
  localparam bit SAT_WRAP   = 1'b0;
  localparam bit SAT_HOLD   = 1'b1;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  // Number of bits needed to represent value (at least 1).
  function automatic int unsigned bits_for(input int unsigned value);
    int unsigned n;
    n = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  // MODULUS must fit the count range 0..MODULUS-1 into WIDTH bits.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned modulus);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (modulus >= 2) && (bits_for(modulus - 1) <= width);
  endfunction

endpackage

// File: rtl/counter_updown_mod_tick_edge_sync.sv
// Synchronises the asynchronous Tick strobe and turns it into a one-clock count step
// (rising-edge mode) or a per-clock step while high (level mode).
module tick_edge_sync
  import counter_updown_mod_pkg::*;
(
  input  logic Clk,
  input  logic Clr,
  input  logic Tick,
  input  logic Mode,
  output logic step
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Two metastability flops followed by a history flop for edge detection.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= Tick;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign step = (Mode == MODE_EDGE) ? (r_s2 & ~r_s3) : r_s2;

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised modulo up/down counter with parallel load, wrap/saturate bounds and a
// synchronised count strobe; feeds the hex/LED display decoders.
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MODULUS   = 256,
  parameter bit          SATURATE  = SAT_WRAP,
  parameter bit          EDGE_MODE = MODE_EDGE
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Tick,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap,
  output logic             AtMax,
  output logic             AtZero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if (!cfg_ok(WIDTH, MODULUS)) begin : g_cfg_err
    $error("counter_updown_mod: WIDTH=%0d MODULUS=%0d out of range", WIDTH, MODULUS);
  end

  logic             w_step;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  tick_edge_sync u_sync (
    .Clk  (Clk),
    .Clr  (Clr),
    .Tick (Tick),
    .Mode (EDGE_MODE),
    .step (w_step)
  );

  // Next count: load beats a coincident step; bound events flag Wrap in both modes.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (Load) begin
      w_q_next = (D > MAX_VAL) ? MAX_VAL : D;
    end else if (w_step && En) begin
      if (Up) begin
        if (r_q == MAX_VAL) begin
          w_wrap_next = 1'b1;
          if (SATURATE == SAT_WRAP) w_q_next = '0;
        end else begin
          w_q_next = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_wrap_next = 1'b1;
          if (SATURATE == SAT_WRAP) w_q_next = MAX_VAL;
        end else begin
          w_q_next = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign Q      = r_q;
  assign Wrap   = r_wrap;
  assign AtMax  = (r_q == MAX_VAL);
  assign AtZero = (r_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: four configurations share one stimulus stream and are
// checked every cycle against an arithmetic counter model plus directed literals.
module tb_counter_updown_mod;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       En;
  logic       Up;
  logic       Tick;
  logic       Load;
  logic [7:0] D;

  logic [7:0] q0, q3;
  logic [3:0] q1, q2;
  logic       wr0, wr1, wr2, wr3;
  logic       mx0, mx1, mx2, mx3;
  logic       zr0, zr1, zr2, zr3;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_on = 1'b0;

  counter_updown_mod #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0), .EDGE_MODE(1'b1)) u0 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Tick(Tick), .Load(Load), .D(D),
    .Q(q0), .Wrap(wr0), .AtMax(mx0), .AtZero(zr0));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .EDGE_MODE(1'b1)) u1 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Tick(Tick), .Load(Load), .D(D[3:0]),
    .Q(q1), .Wrap(wr1), .AtMax(mx1), .AtZero(zr1));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .EDGE_MODE(1'b1)) u2 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Tick(Tick), .Load(Load), .D(D[3:0]),
    .Q(q2), .Wrap(wr2), .AtMax(mx2), .AtZero(zr2));
  counter_updown_mod #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0), .EDGE_MODE(1'b0)) u3 (
    .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Tick(Tick), .Load(Load), .D(D),
    .Q(q3), .Wrap(wr3), .AtMax(mx3), .AtZero(zr3));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modulo arithmetic on the count, Tick seen two edges late.
  int unsigned m_mod  [4] = '{256, 10, 10, 256};
  bit          m_sat  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit          m_edge [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int unsigned m_dmask[4] = '{255, 15, 15, 255};
  int unsigned m_q    [4];
  bit          m_wrap [4];
  bit          t_hist [3];
  bit          m_stepped;
  int unsigned m_dv;

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < 4; i++) begin
        m_q[i]    = 0;
        m_wrap[i] = 1'b0;
      end
      for (int k = 0; k < 3; k++) t_hist[k] = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_stepped = m_edge[i] ? (t_hist[1] && !t_hist[2]) : t_hist[1];
        m_wrap[i] = 1'b0;
        if (Load) begin
          m_dv   = 32'(D) & m_dmask[i];
          m_q[i] = (m_dv < m_mod[i]) ? m_dv : m_mod[i] - 1;
        end else if (m_stepped && En) begin
          if (Up) begin
            if (m_q[i] == m_mod[i] - 1) begin
              m_wrap[i] = 1'b1;
              if (!m_sat[i]) m_q[i] = 0;
            end else m_q[i] = m_q[i] + 1;
          end else begin
            if (m_q[i] == 0) begin
              m_wrap[i] = 1'b1;
              if (!m_sat[i]) m_q[i] = m_mod[i] - 1;
            end else m_q[i] = m_q[i] - 1;
          end
        end
      end
      t_hist[2] = t_hist[1];
      t_hist[1] = t_hist[0];
      t_hist[0] = Tick;
    end
  end

  logic [31:0] a_q [4];
  logic [31:0] a_w [4];
  logic [31:0] a_mx[4];
  logic [31:0] a_zr[4];

  always @(negedge Clk) begin
    if (chk_on) begin
      a_q  = '{32'(q0), 32'(q1), 32'(q2), 32'(q3)};
      a_w  = '{32'(wr0), 32'(wr1), 32'(wr2), 32'(wr3)};
      a_mx = '{32'(mx0), 32'(mx1), 32'(mx2), 32'(mx3)};
      a_zr = '{32'(zr0), 32'(zr1), 32'(zr2), 32'(zr3)};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model u%0d.Q", i), a_q[i], m_q[i]);
        chk($sformatf("model u%0d.Wrap", i), a_w[i], 32'(m_wrap[i]));
        chk($sformatf("model u%0d.AtMax", i), a_mx[i], 32'(m_q[i] == m_mod[i] - 1));
        chk($sformatf("model u%0d.AtZero", i), a_zr[i], 32'(m_q[i] == 0));
      end
    end
  end

  task automatic tick_pulse();
    Tick = 1'b1;
    @(negedge Clk);
    Tick = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic load_val(input logic [7:0] v);
    Load = 1'b1;
    D    = v;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  initial begin
    Clr = 1'b1; En = 1'b0; Up = 1'b1; Tick = 1'b0; Load = 1'b0; D = '0;
    repeat (3) @(negedge Clk);
    Clr = 1'b0;
    chk_on = 1'b1;
    chk("reset u0.Q", 32'(q0), 0);
    chk("reset u0.Wrap", 32'(wr0), 0);
    chk("reset u0.AtZero", 32'(zr0), 1);
    chk("reset u0.AtMax", 32'(mx0), 0);

    // Held Tick: exactly one step, two edges after first sample.
    En = 1'b1; Up = 1'b1; Tick = 1'b1;
    @(negedge Clk); chk("edge lat N u0.Q", 32'(q0), 0);
    @(negedge Clk); chk("edge lat N+1 u0.Q", 32'(q0), 0);
    @(negedge Clk); chk("edge lat N+2 u0.Q", 32'(q0), 1);
    repeat (7) @(negedge Clk);
    chk("edge held u0.Q", 32'(q0), 1);
    Tick = 1'b0;
    repeat (4) @(negedge Clk);

    // Wrap up then down on MODULUS=10.
    load_val(8'd9);
    tick_pulse();
    chk("wrap up u1.Q", 32'(q1), 0);
    chk("wrap up u1.Wrap", 32'(wr1), 1);
    chk("sat up u2.Q", 32'(q2), 9);
    @(negedge Clk); chk("wrap up drop u1.Wrap", 32'(wr1), 0);
    Up = 1'b0;
    tick_pulse();
    chk("wrap down u1.Q", 32'(q1), 9);
    chk("wrap down u1.Wrap", 32'(wr1), 1);
    @(negedge Clk);

    // Saturate at both bounds.
    Up = 1'b1;
    load_val(8'd9);
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      chk("sat hold u2.Q", 32'(q2), 9);
      chk("sat hold u2.Wrap", 32'(wr2), 1);
    end
    @(negedge Clk); chk("sat drop u2.Wrap", 32'(wr2), 0);
    Up = 1'b0;
    load_val(8'd0);
    tick_pulse();
    chk("sat zero u2.Q", 32'(q2), 0);
    chk("sat zero u2.Wrap", 32'(wr2), 1);
    @(negedge Clk);

    // Load with coincident step: clamp, no Wrap, step discarded.
    Up = 1'b1; Tick = 1'b1;
    @(negedge Clk); Tick = 1'b0;
    @(negedge Clk);
    load_val(8'd15);
    chk("load prio u0.Q", 32'(q0), 15);
    chk("load prio u0.Wrap", 32'(wr0), 0);
    chk("load clamp u1.Q", 32'(q1), 9);
    chk("load clamp u1.Wrap", 32'(wr1), 0);
    chk("load clamp u2.Q", 32'(q2), 9);
    @(negedge Clk); chk("load no late step u0.Q", 32'(q0), 15);

    // Level mode advances once per synchronised high cycle.
    load_val(8'd100);
    Tick = 1'b1; repeat (5) @(negedge Clk);
    Tick = 1'b0; repeat (3) @(negedge Clk);
    chk("level +5 u3.Q", 32'(q3), 105);
    chk("edge once u0.Q", 32'(q0), 101);
    En = 1'b0;
    Tick = 1'b1; repeat (5) @(negedge Clk);
    Tick = 1'b0; repeat (3) @(negedge Clk);
    En = 1'b1;
    chk("en low u3.Q", 32'(q3), 105);
    chk("en low u0.Q", 32'(q0), 101);
    repeat (3) @(negedge Clk);
    chk("en low consumed u0.Q", 32'(q0), 101);
    Up = 1'b1; Tick = 1'b1;
    repeat (3) @(negedge Clk);
    Up = 1'b0;
    repeat (3) @(negedge Clk);
    Tick = 1'b0; repeat (3) @(negedge Clk);
    chk("up toggle u3.Q", 32'(q3), 101);
    chk("up toggle u0.Q", 32'(q0), 102);

    // Async clear between edges, then Tick still high at release.
    Up = 1'b1;
    load_val(8'h37);
    chk("pre clr u0.Q", 32'(q0), 32'h37);
    #2 Clr = 1'b1;
    #1;
    chk("async clr u0.Q", 32'(q0), 0);
    chk("async clr u0.Wrap", 32'(wr0), 0);
    chk("async clr u0.AtZero", 32'(zr0), 1);
    Tick = 1'b1;
    @(negedge Clk); Clr = 1'b0;
    @(negedge Clk); chk("post clr N u0.Q", 32'(q0), 0);
    @(negedge Clk); chk("post clr N+1 u0.Q", 32'(q0), 0);
    @(negedge Clk); chk("post clr N+2 u0.Q", 32'(q0), 1);
    Tick = 1'b0;
    repeat (3) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised modulo up/down counter. It is the next generation of the fixed 8-bit enable/clear counter used on the board. It adds selectable width, modulus, direction, parallel load, wrap/saturate mode and a built-in synchroniser/edge detector on the count strobe. It sits between a debounced button or switch strobe and the hex/LED display decoders.

Parameters:
WIDTH, 8, counter bit width (2..16)
MODULUS, 256, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds
EDGE_MODE, 1, 1 = count once per rising edge of Tick, 0 = count every clock while Tick is high

Ports:
Clk  in  1  system clock (CLOCK_50 domain)
Clr  in  1  asynchronous active-high reset
En  in  1  count enable, synchronous
Up  in  1  direction: 1 = up, 0 = down
Tick  in  1  count strobe, asynchronous to Clk (button/switch)
Load  in  1  synchronous parallel load
D  in  WIDTH  load value
Q  out  WIDTH  current count
Wrap  out  1  one-cycle pulse when count wraps or hits a bound
AtMax  out  1  combinational: Q == MODULUS-1
AtZero  out  1  combinational: Q == 0

Behaviour:
- Interface: one clock, Clk. Reset Clr is asynchronous and active-high. All state is cleared immediately on Clr high, independent of Clk.
- Reset values: Q=0, Wrap=0, synchroniser flops=0. AtZero=1 and AtMax=0 follow from Q.
- Strobe path, EDGE_MODE=1:
  - Tick passes through 2 synchroniser flops (s1, s2) plus a history flop s3.
  - step = s2 & ~s3.
  - If Tick is first sampled high at edge N, Q updates at edge N+2.
  - A high Tick held for any length of time produces exactly one step.
- Strobe path, EDGE_MODE=0: step = s2, giving one step per clock while the synchronised Tick is high. Latency is the same as EDGE_MODE=1.
- Priority at each rising Clk edge: Clr (async) > Load > count.
- Load:
  - Q <= D if D < MODULUS, else Q <= MODULUS-1 (clamp).
  - Wrap <= 0.
  - A step arriving in the same cycle is discarded.
- Count occurs when step & En & ~Load:
  - Up=1, Q<MODULUS-1: Q <= Q+1.
  - Up=1, Q==MODULUS-1: SATURATE=0 gives Q <= 0; SATURATE=1 holds Q. Wrap <= 1 in both cases.
  - Up=0, Q>0: Q <= Q-1.
  - Up=0, Q==0: SATURATE=0 gives Q <= MODULUS-1; SATURATE=1 holds Q. Wrap <= 1 in both cases.
- Wrap is registered, high for exactly the one cycle after the edge that applied the bound event. It is 0 otherwise.
- En low: Q holds. Steps are lost, not queued. Synchroniser flops keep running, so a Tick edge occurring while En is low is consumed.
- Up is sampled on the counting edge only. Changing Up between steps is legal.
- Clr asserted mid-count: Q=0 and synchroniser flops clear. If Tick is still high when Clr releases, EDGE_MODE=1 produces one step 2 edges later.
- Arithmetic is at WIDTH bits. No intermediate value may exceed MODULUS-1, so no overflow path exists.

Decomposition:
- Shared include/package: clog2-style width helper, EDGE_MODE/SATURATE mode constants, MODULUS range check (elaboration-time error when out of range).
- One sub-module, tick_edge_sync:
  - Ports: Clk, Clr, Tick, Mode (EDGE_MODE), step.
  - Contents: 2-flop synchroniser, history flop, edge/level select.
- Counter core stays in counter_updown_mod.

Test Plan:
- Reset and edge step (WIDTH=8, MODULUS=256, EDGE_MODE=1): Clr pulse, then Up=1, En=1, Tick high for 10 cycles → Q=0 after reset; Q=1 exactly 2 edges after Tick first sampled; Q stays 1 while Tick is held.
- Wrap up, MODULUS=10, SATURATE=0: Load D=9, then one Tick edge → Q=0, Wrap high for 1 cycle. Repeat with Up=0 from Q=0 → Q=9, Wrap pulse.
- Saturate, MODULUS=10, SATURATE=1: Q=9, Up=1, 3 Tick edges → Q stays 9, Wrap pulses on each edge. Down from 0 → Q stays 0.
- Load clamp and priority: MODULUS=10, D=15, Load=1 coincident with step → Q=9, Wrap=0, step discarded.
- Level mode and enable (EDGE_MODE=0): Tick high for 5 cycles, En=1 → Q advances by 5. Repeat with En=0 → Q unchanged. Toggle Up mid-run → direction follows Up.
- Async reset mid-operation: Q=0x37, assert Clr between clock edges → Q=0 before the next Clk edge, Wrap=0, AtZero=1.
